uart_frame_ctrl: RTL
====================

Name: uart_frame_ctrl

Overview:
- Frame-level controller on the UART receive byte stream (rx_flag/rx_data strobe from the serial receiver).
- Hunts for a header byte and parses ADDR, LEN, payload and checksum into an internal buffer.
- On a valid frame, issues a burst of register writes over a valid/ready write port.
- Flags length, checksum, inter-byte timeout and overrun errors; sits between the serial receiver and the register bank it configures.

Parameters:
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz.
- UART_BPS, 9600: line baud rate; sets the timeout scale.
- HEADER, 8'hA5: frame start byte.
- MAX_LEN, 8: maximum payload bytes (1..16); sets buffer depth.
- TIMEOUT_BYTES, 3: allowed inter-byte gap in character times. TIMEOUT_CYC = (CLK_FREQ/UART_BPS)*10*TIMEOUT_BYTES.

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset
- rx_flag  in  1  one-cycle strobe: rx_data valid
- rx_data  in  8  received byte
- wr_valid  out  1  write request
- wr_ready  in  1  register bank accepts the write
- wr_addr  out  8  write address
- wr_data  out  8  write data
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  pulse: burst complete
- err_len  out  1  pulse: LEN is 0 or greater than MAX_LEN
- err_crc  out  1  pulse: checksum mismatch
- err_timeout  out  1  pulse: inter-byte gap expired mid-frame
- err_ovr  out  1  pulse: byte arrived during BURST and was dropped

Behaviour:
- Reset: sys_rst_n is asynchronous and active-low; clock is sys_clk. All outputs reset to 0, state resets to IDLE, buffer contents are don't-care. Reset mid-frame or mid-burst aborts immediately; no further wr_valid is issued.
- Frame format: HEADER, ADDR, LEN, D0..D(LEN-1), CSUM.
  - CSUM = (ADDR + LEN + sum of Di) mod 256.
  - The header is not included in the sum.
- All outputs are registered. Every pulse output is high for exactly 1 cycle.
- IDLE:
  - rx_flag with rx_data==HEADER moves to ADDR.
  - Any other byte is ignored silently.
- ADDR: on rx_flag, latch base address, clear sum, sum=rx_data, go to LEN.
- LEN: on rx_flag:
  - rx_data==0 or >MAX_LEN: err_len next cycle, go to IDLE.
  - Otherwise latch len, sum+=rx_data, idx=0, go to DATA.
- DATA: on rx_flag, buf[idx]=rx_data, sum+=rx_data, idx++. When idx reaches len, go to CSUM.
- CSUM: on rx_flag:
  - Mismatch: err_crc next cycle, go to IDLE. No writes are issued.
  - Match: go to BURST, idx=0.
- BURST:
  - wr_valid asserts the cycle after the CSUM rx_flag.
  - wr_addr = (base+idx) mod 256, wrapping at 8'hFF to 8'h00. wr_data = buf[idx].
  - On wr_valid&&wr_ready: idx++ and the next address/data are presented the following cycle; wr_valid stays high.
  - After the final handshake: wr_valid drops, frame_done pulses, go to IDLE. All three happen on the same next edge.
  - wr_addr/wr_data are held stable while wr_valid&&!wr_ready.
  - wr_ready is ignored when wr_valid is low.
- Overrun: rx_flag in BURST drops the byte and pulses err_ovr. The burst continues unaffected.
- Timeout:
  - The 32-bit counter runs only in ADDR/LEN/DATA/CSUM. It clears on entry to these states and on every rx_flag.
  - At TIMEOUT_CYC-1: err_timeout next cycle, go to IDLE, partial frame discarded.
  - If rx_flag coincides with the expiry cycle, the byte wins: it is processed and the counter clears.
- A HEADER value received inside a frame is treated as data; there is no resync.
- Error pulses and frame_done never assert together for the same frame.

Test Plan:
- A5 10 02 11 22 45, wr_ready tied 1 -> writes (10,11),(11,22) on consecutive cycles; frame_done 1 cycle after the second; no error pulses.
- A5 FF 02 AA BB 66 -> writes (FF,AA),(00,BB), confirming address wrap.
- Same as the first frame but CSUM=46 -> err_crc pulse, wr_valid never asserts, state returns to IDLE. A following valid frame is then accepted.
- A5 10 00 and, separately, A5 10 09 -> err_len pulse each time, no writes.
- A5 10 02 11 then silence for TIMEOUT_CYC cycles -> err_timeout exactly once, busy drops. A following full frame succeeds.
- Valid frame with wr_ready held 0 for 20 cycles, and rx_flag with 0x77 injected during BURST -> wr_addr/wr_data stable while stalled; err_ovr pulses once; both writes still complete correctly.

Source files
------------

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: parses HEADER/ADDR/LEN/payload/CSUM frames from the UART
// byte stream and replays the payload as a valid/ready register write burst.
module uart_frame_ctrl #(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned UART_BPS      = 9600,
    parameter logic [7:0]  HEADER        = 8'hA5,
    parameter int unsigned MAX_LEN       = 8,
    parameter int unsigned TIMEOUT_BYTES = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx_flag,
    input  logic [7:0] rx_data,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       frame_done,
    output logic       err_len,
    output logic       err_crc,
    output logic       err_timeout,
    output logic       err_ovr
);
    localparam int unsigned TIMEOUT_CYC = (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES;
    localparam int unsigned IW = $clog2(MAX_LEN + 1);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_BURST
    } state_t;

    state_t        state_q;
    logic [7:0]    base_q;
    logic [7:0]    sum_q;
    logic [IW-1:0] len_q;
    logic [IW-1:0] idx_q;
    logic [31:0]   cnt_q;
    logic [7:0]    buf_q [2**AW];

    logic [IW-1:0] idx_d;
    logic [7:0]    sum_d;
    logic [31:0]   cnt_d;
    logic          in_frame;
    logic          to_hit;

    always_comb begin
        idx_d    = idx_q + 1'b1;
        sum_d    = sum_q + rx_data;
        in_frame = (state_q == S_ADDR) || (state_q == S_LEN) ||
                   (state_q == S_DATA) || (state_q == S_CSUM);
        cnt_d    = rx_flag ? '0 : cnt_q + 32'd1;
        // an arriving byte beats an expiring gap counter
        to_hit   = in_frame && !rx_flag && (cnt_q == TO_LAST);
    end

    always_ff @(posedge sys_clk) begin
        if (state_q == S_DATA && rx_flag) buf_q[idx_q[AW-1:0]] <= rx_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            sum_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_len     <= 1'b0;
            err_crc     <= 1'b0;
            err_timeout <= 1'b0;
            err_ovr     <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            err_len     <= 1'b0;
            err_crc     <= 1'b0;
            err_timeout <= 1'b0;
            err_ovr     <= 1'b0;
            if (in_frame) cnt_q <= cnt_d;
            if (to_hit) begin
                err_timeout <= 1'b1;
                busy        <= 1'b0;
                state_q     <= S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (rx_flag && rx_data == HEADER) begin
                            cnt_q   <= '0;
                            busy    <= 1'b1;
                            state_q <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        if (rx_flag) begin
                            base_q  <= rx_data;
                            sum_q   <= rx_data;
                            state_q <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (rx_flag) begin
                            if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                                err_len <= 1'b1;
                                busy    <= 1'b0;
                                state_q <= S_IDLE;
                            end else begin
                                len_q   <= rx_data[IW-1:0];
                                sum_q   <= sum_d;
                                idx_q   <= '0;
                                state_q <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (rx_flag) begin
                            sum_q <= sum_d;
                            idx_q <= idx_d;
                            if (idx_d == len_q) state_q <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (rx_flag) begin
                            if (rx_data != sum_q) begin
                                err_crc <= 1'b1;
                                busy    <= 1'b0;
                                state_q <= S_IDLE;
                            end else begin
                                idx_q    <= '0;
                                wr_valid <= 1'b1;
                                wr_addr  <= base_q;
                                wr_data  <= buf_q[{AW{1'b0}}];
                                state_q  <= S_BURST;
                            end
                        end
                    end
                    S_BURST: begin
                        if (rx_flag) err_ovr <= 1'b1;
                        if (wr_valid && wr_ready) begin
                            if (idx_d == len_q) begin
                                wr_valid   <= 1'b0;
                                frame_done <= 1'b1;
                                busy       <= 1'b0;
                                state_q    <= S_IDLE;
                            end else begin
                                idx_q   <= idx_d;
                                wr_addr <= wr_addr + 8'd1;
                                wr_data <= buf_q[idx_d[AW-1:0]];
                            end
                        end
                    end
                    default: begin
                        busy    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule
